// File: rtl/stack_seq_pkg.sv
`default_nettype none
// ============================================================================
// stack_seq_pkg : shared types and constants for the 65C02 stack sequencer
// Revision 1.0
// ============================================================================
package stack_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_PULL_INC = 3'd2,
        ST_PULL_RD  = 3'd3,
        ST_DONE     = 3'd4
    } stack_state_t;

    localparam logic       OP_PUSH            = 1'b0;
    localparam logic       OP_PULL            = 1'b1;
    localparam logic [7:0] DEFAULT_STACK_PAGE = 8'h01;

endpackage : stack_seq_pkg
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// stack_sequencer : bus-cycle sequencer for 1-3 byte stack pushes and pulls
// Revision 1.0
// ============================================================================
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = DEFAULT_STACK_PAGE
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_count,
    input  logic [23:0] push_data,
    input  logic [7:0]  sp_in,
    output logic        sp_increment,
    output logic        sp_decrement,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out,
    output logic        we_out,
    output logic        re_out,
    input  logic [7:0]  data_in,
    output logic [23:0] pull_data,
    output logic        busy,
    output logic        done
);

    stack_state_t state;
    stack_state_t next_state;

    logic [1:0]  lat_count;
    logic [1:0]  remaining;
    logic [23:0] push_buf;
    logic [1:0]  eff_count;
    logic        accept;
    logic [1:0]  pull_idx;
    logic [7:0]  push_byte;

    assign eff_count = (req_count == 2'd0) ? 2'd1 : req_count;
    assign accept    = req_valid && (state == ST_IDLE);
    // Pulled bytes fill from the low byte up as remaining counts down.
    assign pull_idx  = lat_count - remaining;

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (req_op == OP_PULL) ? ST_PULL_INC : ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (remaining <= 2'd1) begin
                    next_state = ST_DONE;
                end
            end
            ST_PULL_INC: next_state = ST_PULL_RD;
            ST_PULL_RD: begin
                if (remaining <= 2'd1) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Highest remaining byte goes out first, so [7:0] is always the last push.
    always_comb begin
        push_byte = push_buf[7:0];
        case (remaining)
            2'd3:    push_byte = push_buf[23:16];
            2'd2:    push_byte = push_buf[15:8];
            default: push_byte = push_buf[7:0];
        endcase
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            lat_count <= 2'd1;
            remaining <= 2'd0;
            push_buf  <= 24'h000000;
            pull_data <= 24'h000000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_count <= eff_count;
                        remaining <= eff_count;
                        push_buf  <= push_data;
                        if (req_op == OP_PULL) begin
                            pull_data <= 24'h000000;
                        end
                    end
                end
                ST_PUSH: remaining <= remaining - 2'd1;
                ST_PULL_RD: begin
                    remaining <= remaining - 2'd1;
                    case (pull_idx)
                        2'd0:    pull_data[7:0]   <= data_in;
                        2'd1:    pull_data[15:8]  <= data_in;
                        default: pull_data[23:16] <= data_in;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        sp_increment = 1'b0;
        sp_decrement = 1'b0;
        we_out       = 1'b0;
        re_out       = 1'b0;
        addr_out     = 16'h0000;
        data_out     = 8'h00;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_PUSH: begin
                we_out       = 1'b1;
                sp_decrement = 1'b1;
                addr_out     = {STACK_PAGE, sp_in};
                data_out     = push_byte;
            end
            ST_PULL_INC: sp_increment = 1'b1;
            ST_PULL_RD: begin
                re_out       = 1'b1;
                addr_out     = {STACK_PAGE, sp_in};
                sp_increment = (remaining > 2'd1);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule : stack_sequencer
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// tb_stack_sequencer : scoreboard bench with stack memory and SP register model
// Revision 1.0
// ============================================================================
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    logic        fclk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [1:0]  req_count = 2'd0;
    logic [23:0] push_data = 24'h0;
    logic [7:0]  sp_in;
    logic        sp_increment, sp_decrement;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        we_out, re_out;
    logic [7:0]  data_in;
    logic [23:0] pull_data;
    logic        busy, done;

    stack_sequencer #(.STACK_PAGE(8'h01)) dut (
        .fclk(fclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_count(req_count), .push_data(push_data), .sp_in(sp_in),
        .sp_increment(sp_increment), .sp_decrement(sp_decrement), .addr_out(addr_out),
        .data_out(data_out), .we_out(we_out), .re_out(re_out), .data_in(data_in),
        .pull_data(pull_data), .busy(busy), .done(done)
    );

    always #5 fclk = ~fclk;

    // Environment: stack pointer register and stack page memory
    logic [7:0] sp_reg = 8'h00;
    logic [7:0] mem [0:255];
    logic       sp_load = 1'b0;
    logic [7:0] sp_load_val = 8'h00;
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00, poke_val = 8'h00;

    always @(posedge fclk) begin
        if (sp_load) sp_reg <= sp_load_val;
        else if (sp_increment) sp_reg <= sp_reg + 8'd1;
        else if (sp_decrement) sp_reg <= sp_reg - 8'd1;
        if (poke_en) mem[poke_addr] <= poke_val;
        else if (we_out) mem[addr_out[7:0]] <= data_out;
    end
    assign sp_in   = sp_reg;
    assign data_in = mem[addr_out[7:0]];

    typedef struct {logic we; logic [15:0] addr; logic [7:0] data;} bus_t;
    typedef struct {logic op; int lat; logic [23:0] pd; logic [7:0] sp;} cmp_t;

    bus_t bus_q[$];
    cmp_t cmp_q[$];
    int   acc_q[$];
    logic [7:0] model_mem [0:255];
    logic [7:0] model_sp = 8'h00;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   expect_off = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stack semantics in plain array/queue terms
    task automatic model(input logic op, input logic [1:0] cnt, input logic [23:0] d);
        int n;
        logic [23:0] res;
        n = (cnt == 2'd0) ? 1 : int'(cnt);
        res = 24'h0;
        if (op == OP_PUSH) begin
            for (int i = n - 1; i >= 0; i--) begin
                bus_q.push_back('{1'b1, {8'h01, model_sp}, d[i*8 +: 8]});
                model_mem[model_sp] = d[i*8 +: 8];
                model_sp = model_sp - 8'd1;
            end
            cmp_q.push_back('{op, n + 1, 24'h0, model_sp});
        end else begin
            for (int i = 0; i < n; i++) begin
                model_sp = model_sp + 8'd1;
                bus_q.push_back('{1'b0, {8'h01, model_sp}, 8'h00});
                res[i*8 +: 8] = model_mem[model_sp];
            end
            cmp_q.push_back('{op, n + 2, res, model_sp});
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs
    always @(negedge fclk) begin
        bus_t e;
        cmp_t c;
        int   a;
        #2;
        cyc++;
        if (!reset && !expect_off) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            check("sp_strobe_excl", {31'd0, sp_increment & sp_decrement}, 32'd0);
            check("we_re_excl", {31'd0, we_out & re_out}, 32'd0);
            if (we_out || re_out) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", {30'd0, we_out, re_out}, 32'd0);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_we", {31'd0, we_out}, {31'd0, e.we});
                    check("bus_addr", {16'd0, addr_out}, {16'd0, e.addr});
                    if (e.we) begin
                        check("bus_wdata", {24'd0, data_out}, {24'd0, e.data});
                        check("bus_dec", {31'd0, sp_decrement}, 32'd1);
                    end else begin
                        check("rd_wdata_zero", {24'd0, data_out}, 32'd0);
                    end
                end
            end else begin
                check("idle_addr", {16'd0, addr_out}, 32'd0);
                check("idle_wdata", {24'd0, data_out}, 32'd0);
            end
            if (done) begin
                if (cmp_q.size() == 0 || acc_q.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    c = cmp_q.pop_front();
                    a = acc_q.pop_front();
                    check("done_latency", cyc - a, c.lat);
                    check("done_sp", {24'd0, sp_reg}, {24'd0, c.sp});
                    check("done_busy", {30'd0, busy, req_ready}, 32'd2);
                    if (c.op == OP_PULL) check("pull_data", {8'd0, pull_data}, {8'd0, c.pd});
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        model_mem[a] = v;
        @(negedge fclk);
        poke_en = 1'b0;
    endtask

    task automatic setsp(input logic [7:0] v);
        sp_load = 1'b1; sp_load_val = v;
        model_sp = v;
        @(negedge fclk);
        sp_load = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [1:0] cnt, input logic [23:0] d);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge fclk); t++; end
        if (!req_ready) check("issue_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_op = op; req_count = cnt; push_data = d;
        model(op, cnt, d);
        @(negedge fclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus_q.size() != 0 || cmp_q.size() != 0 || !req_ready) && t < 200) begin
            @(negedge fclk); t++;
        end
        if (t >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) poke(i[7:0], 8'($urandom));
        setsp(8'hFF);
        check("rst_hold_ready", {31'd0, req_ready}, 32'd1);
        @(negedge fclk);
        reset = 1'b0;
        @(negedge fclk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobes", {28'd0, sp_increment, sp_decrement, we_out, re_out}, 32'd0);
        check("rst_addr", {16'd0, addr_out}, 32'd0);
        check("rst_pull_data", {8'd0, pull_data}, 32'd0);

        // JSR-style push
        setsp(8'hFF);
        issue(OP_PUSH, 2'd2, 24'h001234);
        wait_idle();
        check("jsr_mem_ff", {24'd0, mem[8'hFF]}, 32'h12);
        check("jsr_mem_fe", {24'd0, mem[8'hFE]}, 32'h34);
        check("jsr_sp", {24'd0, sp_reg}, 32'hFD);

        // RTI-style pull
        setsp(8'hFC);
        poke(8'hFD, 8'hA5); poke(8'hFE, 8'h00); poke(8'hFF, 8'h80);
        issue(OP_PULL, 2'd3, 24'h0);
        wait_idle();
        check("rti_pull_data", {8'd0, pull_data}, 32'h8000A5);
        check("rti_sp", {24'd0, sp_reg}, 32'hFF);

        // Wrap-around push at SP = 00
        setsp(8'h00);
        issue(OP_PUSH, 2'd1, 24'hFFFF5A);
        wait_idle();
        check("wrap_mem", {24'd0, mem[8'h00]}, 32'h5A);
        check("wrap_sp", {24'd0, sp_reg}, 32'hFF);

        // Count-0 pull with req_valid held (and fields scrambled) while busy
        setsp(8'h40);
        poke(8'h41, 8'h77);
        req_valid = 1'b1; req_op = OP_PULL; req_count = 2'd0; push_data = 24'($urandom);
        model(OP_PULL, 2'd0, 24'h0);
        for (t = 0; t < 20 && !done; t++) begin
            @(negedge fclk);
            req_op = OP_PUSH; req_count = 2'd3; push_data = 24'($urandom);
        end
        req_valid = 1'b0;
        if (t >= 20) check("busy_timeout", 32'd0, 32'd1);
        wait_idle();
        check("cnt0_pull_data", {8'd0, pull_data}, 32'h77);
        check("cnt0_sp", {24'd0, sp_reg}, 32'h41);

        // Back-to-back: push 1 then pull 1 with req_valid held
        setsp(8'h30);
        req_valid = 1'b1; req_op = OP_PUSH; req_count = 2'd1; push_data = 24'h0000C3;
        model(OP_PUSH, 2'd1, 24'h0000C3);
        for (t = 0; t < 20 && !done; t++) @(negedge fclk);
        req_op = OP_PULL; req_count = 2'd1;
        model(OP_PULL, 2'd1, 24'h0);
        @(negedge fclk);
        check("b2b_ready_after_done", {31'd0, req_ready}, 32'd1);
        @(negedge fclk);
        req_valid = 1'b0;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_idle();
        check("b2b_pull_data", {8'd0, pull_data}, 32'hC3);

        // Reset mid-push (count 3)
        setsp(8'h80);
        expect_off = 1'b1;
        req_valid = 1'b1; req_op = OP_PUSH; req_count = 2'd3; push_data = 24'hABCDEF;
        @(negedge fclk); req_valid = 1'b0;
        @(negedge fclk);
        check("rstpush_pre_we", {31'd0, we_out}, 32'd1);
        reset = 1'b1; #1;
        check("rstpush_we", {31'd0, we_out}, 32'd0);
        check("rstpush_busy", {31'd0, busy}, 32'd0);
        check("rstpush_ready", {31'd0, req_ready}, 32'd1);
        check("rstpush_dec", {31'd0, sp_decrement}, 32'd0);
        check("rstpush_pull_data", {8'd0, pull_data}, 32'd0);
        @(negedge fclk);
        check("rstpush_next_we", {31'd0, we_out}, 32'd0);
        reset = 1'b0;
        for (int a = 8'h7C; a <= 8'h80; a++) poke(a[7:0], model_mem[a[7:0]]);
        setsp(8'h50);
        poke(8'h51, 8'h9C);

        // Reset mid-pull clears partially assembled pull_data
        req_valid = 1'b1; req_op = OP_PULL; req_count = 2'd3;
        @(negedge fclk); req_valid = 1'b0;
        @(negedge fclk);
        @(negedge fclk);
        check("rstpull_partial", {24'd0, pull_data[7:0]}, 32'h9C);
        reset = 1'b1; #1;
        check("rstpull_pull_data", {8'd0, pull_data}, 32'd0);
        check("rstpull_re_inc", {30'd0, re_out, sp_increment}, 32'd0);
        @(negedge fclk);
        reset = 1'b0;
        setsp(8'($urandom));
        expect_off = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 120; k++) begin
            issue(1'($urandom), 2'($urandom), 24'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge fclk);
        end
        wait_idle();
        repeat (3) @(negedge fclk);
        check("bus_q_empty", bus_q.size(), 32'd0);
        check("cmp_q_empty", cmp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stack_sequencer
`default_nettype wire
